// File: rtl/div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_unit                                                      |
// | Brief    : radix-2 restoring divider for DIV/DIVU/REM/REMU with stall    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            stallreq
);

  localparam int c_CW = $clog2(XLEN);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_count;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic              r_op_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  logic              w_signed;
  logic              w_dnd_neg;
  logic              w_dvs_neg;
  logic [XLEN-1:0]   w_dnd_mag;
  logic [XLEN-1:0]   w_dvs_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_calc_res;

  // Operand decode; the magnitude of the most negative value is itself when read unsigned.
  assign w_signed   = ~op[0];
  assign w_dnd_neg  = w_signed & dividend[XLEN-1];
  assign w_dvs_neg  = w_signed & divisor[XLEN-1];
  assign w_dnd_mag  = w_dnd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~divisor + 1'b1) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == c_MIN_NEG) & (divisor == '1);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = op[1] ? dividend : '1;
    end else begin
      w_special_res = op[1] ? '0 : c_MIN_NEG;
    end
  end

  // One restoring step: the partial remainder is one bit wider than the operands.
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[XLEN-1:0] - r_dvs;
  assign w_rem_nxt  = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
  assign w_q_fix    = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_r_fix    = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
  assign w_calc_res = r_op_rem ? w_r_fix : w_q_fix;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_count == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_op_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!flush) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_quo    <= w_dnd_mag;
              r_rem    <= '0;
              r_dvs    <= w_dvs_mag;
              r_op_rem <= op[1];
              r_neg_q  <= w_dnd_neg ^ w_dvs_neg;
              r_neg_r  <= w_dnd_neg;
              r_count  <= '0;
              if (w_special) begin
                r_result <= w_special_res;
              end
            end
          end
          S_CALC: begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + 1'b1;
            if (r_count == c_LAST) begin
              r_result <= w_calc_res;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign result   = r_result;
  assign ready    = (r_state == S_DONE);
  assign stallreq = ~flush & (((r_state == S_IDLE) & start) | (r_state == S_CALC));

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_div_unit                                                   |
// | Brief    : vector table, corner sequences and random ops vs. ref model   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_div_unit;

  localparam logic [1:0] c_DIV  = 2'b00;
  localparam logic [1:0] c_DIVU = 2'b01;
  localparam logic [1:0] c_REM  = 2'b10;
  localparam logic [1:0] c_REMU = 2'b11;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int failures = 0;

  div_unit #(.XLEN(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .ready    (ready),
    .stallreq (stallreq)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    int sr;
    sa = a;
    sb = b;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      sr = f[1] ? (sa % sb) : (sa / sb);
      return sr;
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issues one op starting at the next falling edge; returns while in the ready cycle.
  task automatic apply(input string name, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit keep);
    int lat = -1;
    int nst = 0;
    logic [31:0] res = '0;
    int exp_lat;
    @(negedge CLK);
    op = f; dividend = a; divisor = b; start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ready) begin
        lat = c;
        res = result;
        break;
      end
      if (stallreq) nst++;
      @(negedge CLK);
    end
    exp_lat = is_special(f, a, b) ? 1 : 33;
    check({name, " latency"}, lat, exp_lat);
    check({name, " stall_cycles"}, nst, exp_lat);
    check({name, " result"}, res, exp);
    check({name, " stall_in_done"}, {31'b0, stallreq}, 32'h0);
    if (!keep) begin
      @(negedge CLK);
      start = 1'b0;
      #1;
      check({name, " ready_one_cycle"}, {31'b0, ready}, 32'h0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] held;
    logic [1:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rk;

    vecs.push_back('{c_DIVU, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{c_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{c_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{c_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{c_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0});
    vecs.push_back('{c_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{c_REMU, 32'd5,          32'd0,          32'd5});
    vecs.push_back('{c_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{c_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
    vecs.push_back('{c_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{c_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF});
    vecs.push_back('{c_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000});
    vecs.push_back('{c_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE});
    vecs.push_back('{c_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000});
    vecs.push_back('{c_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
    vecs.push_back('{c_REM,  32'd7,          32'hFFFF_FFFE,  32'd1});
    vecs.push_back('{c_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0});
    vecs.push_back('{c_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});

    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("reset result", result, 32'h0);
    check("reset ready", {31'b0, ready}, 32'h0);
    check("reset stallreq", {31'b0, stallreq}, 32'h0);

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                            vecs[i].exp, 1'b0);

    // Flush mid-CALC (count 10) with start still held.
    held = 32'd15;
    apply("pre_flush", c_DIVU, 32'd45, 32'd3, held, 1'b0);
    @(negedge CLK);
    op = c_DIVU; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    repeat (11) @(negedge CLK);
    flush = 1'b1;
    #1;
    check("flush stallreq_same_cycle", {31'b0, stallreq}, 32'h0);
    @(negedge CLK);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush stallreq_after", {31'b0, stallreq}, 32'h0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge CLK);
        #1;
        if (ready) seen++;
      end
      check("flush no_ready", seen, 0);
    end
    check("flush result_held", result, held);
    apply("post_flush", c_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Back-to-back with start continuously high.
    apply("b2b_div", c_DIV, 32'd20, 32'd3, 32'd6, 1'b1);
    apply("b2b_remu", c_REMU, 32'd20, 32'd3, 32'd2, 1'b0);

    // Reset in the middle of CALC.
    @(negedge CLK);
    op = c_DIVU; dividend = 32'd777; divisor = 32'd5; start = 1'b1;
    repeat (6) @(negedge CLK);
    RST_N = 1'b0; start = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("midreset result", result, 32'h0);
    check("midreset ready", {31'b0, ready}, 32'h0);
    check("midreset stallreq", {31'b0, stallreq}, 32'h0);
    apply("post_reset", c_REMU, 32'd777, 32'd5, 32'd2, 1'b0);

    // Random ops, mixed with back-to-back issue.
    for (int n = 0; n < 60; n++) begin
      rf = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rk = 1'($urandom_range(0, 1));
      apply($sformatf("rnd%0d", n), rf, ra, rb, ref_div(rf, ra, rb), rk);
    end
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
